// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, serves it from a word
// array after LATENCY cycles and returns rdata/err through a valid/ready response.
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY=%0d outside supported range 1..15", LATENCY);
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [31:0]         r_mem [DEPTH];

    logic                w_req_hs;
    logic                w_resp_hs;
    logic                w_exec;
    logic                w_err;
    logic [ADDR_W-1:0]   w_idx;

    assign w_req_hs  = req_valid & req_ready;
    assign w_resp_hs = resp_valid & resp_ready;
    assign w_exec    = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx     = r_addr[ADDR_W+1:2];
    assign w_err     = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req_hs)        w_next_state = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0)   w_next_state = S_RESP;
            S_RESP:  if (w_resp_hs)       w_next_state = S_IDLE;
            default:                      w_next_state = S_IDLE;
        endcase
    end

    // req_ready is gated by reset so it stays low for as long as reset is held.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE:  req_ready  = reset;
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // NOTE: the array sits in the reset domain because reset must clear every word,
    // so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_req_hs) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_exec) begin
                r_err   <= w_err;
                r_rdata <= (!r_we && !w_err) ? r_mem[w_idx] : 32'd0;
                if (r_we && !w_err) begin
                    for (int b = 0; b < 4; b++)
                        if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end else if (w_resp_hs) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder at LATENCY 1, 2 and 15,
// compared against a word-array model of the load/store rules.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_a  [3];
    logic        req_ready_a  [3];
    logic        req_we_a     [3];
    logic [31:0] req_addr_a   [3];
    logic [31:0] req_wdata_a  [3];
    logic [3:0]  req_wstrb_a  [3];
    logic        resp_valid_a [3];
    logic        resp_ready_a [3];
    logic [31:0] resp_rdata_a [3];
    logic        resp_err_a   [3];

    logic [31:0] model_mem [3][64];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(1), .ADDR_W(6)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_we(req_we_a[0]),
        .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]), .req_wstrb(req_wstrb_a[0]),
        .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready_a[0]),
        .resp_rdata(resp_rdata_a[0]), .resp_err(resp_err_a[0]));

    dmem_responder #(.LATENCY(2), .ADDR_W(6)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_we(req_we_a[1]),
        .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]), .req_wstrb(req_wstrb_a[1]),
        .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready_a[1]),
        .resp_rdata(resp_rdata_a[1]), .resp_err(resp_err_a[1]));

    dmem_responder #(.LATENCY(15), .ADDR_W(6)) u_dut_l15 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]), .req_we(req_we_a[2]),
        .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]), .req_wstrb(req_wstrb_a[2]),
        .resp_valid(resp_valid_a[2]), .resp_ready(resp_ready_a[2]),
        .resp_rdata(resp_rdata_a[2]), .resp_err(resp_err_a[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 15;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_models();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++) model_mem[d][i] = 32'd0;
    endtask

    // Issue one request to instance d, wait for its response, hold it for
    // 'hold' extra cycles (with a spurious request pending), then take it.
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          idx;
        int          w;
        int          e;

        exp_err   = (addr % 4 != 0) || (addr >= 32'd256);
        exp_rdata = 32'd0;
        if (!exp_err) begin
            idx = int'(addr / 4);
            if (!we) exp_rdata = model_mem[d][idx];
            else
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) model_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end

        @(negedge clk);
        req_valid_a[d]  = 1'b1;
        req_we_a[d]     = we;
        req_addr_a[d]   = addr;
        req_wdata_a[d]  = wdata;
        req_wstrb_a[d]  = wstrb;
        resp_ready_a[d] = 1'b0;
        w = 0;
        while (!req_ready_a[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before_accept", 32'(req_ready_a[d]), 32'd1);
        if (!req_ready_a[d]) begin
            req_valid_a[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the request inputs; the latched request must be unaffected.
        req_valid_a[d] = 1'b0;
        req_we_a[d]    = ~we;
        req_addr_a[d]  = $urandom;
        req_wdata_a[d] = $urandom;
        req_wstrb_a[d] = 4'($urandom);

        e = 0;
        while (!resp_valid_a[d] && e < 40) begin
            @(negedge clk);
            e++;
        end
        check($sformatf("latency_L%0d", lat_of(d)), 32'(e), 32'(lat_of(d)));
        check("resp_rdata", resp_rdata_a[d], exp_rdata);
        check("resp_err", 32'(resp_err_a[d]), 32'(exp_err));

        for (int i = 0; i < hold; i++) begin
            req_valid_a[d] = 1'b1;
            req_we_a[d]    = 1'b0;
            req_addr_a[d]  = 32'h0000_0010;
            @(negedge clk);
            check("hold_resp_valid", 32'(resp_valid_a[d]), 32'd1);
            check("hold_resp_rdata", resp_rdata_a[d], exp_rdata);
            check("hold_resp_err", 32'(resp_err_a[d]), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready_a[d]), 32'd0);
        end

        resp_ready_a[d] = 1'b1;
        @(negedge clk);
        req_valid_a[d]  = 1'b0;
        resp_ready_a[d] = 1'b0;
        check("post_hs_resp_valid", 32'(resp_valid_a[d]), 32'd0);
        check("post_hs_resp_rdata", resp_rdata_a[d], 32'd0);
        check("post_hs_req_ready", 32'(req_ready_a[d]), 32'd1);
    endtask

    task automatic rand_req(input int d);
        logic [31:0] addr;
        int          r;
        r = $urandom_range(0, 9);
        if (r < 5)       addr = 32'($urandom_range(0, 7)) << 2;
        else if (r < 8)  addr = 32'($urandom_range(0, 63)) << 2;
        else if (r == 8) addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else             addr = ($urandom | 32'h0000_0100) & 32'hFFFF_FFFC;
        do_req(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_valid_a[d]  = 1'b0;
            req_we_a[d]     = 1'b0;
            req_addr_a[d]   = 32'd0;
            req_wdata_a[d]  = 32'd0;
            req_wstrb_a[d]  = 4'd0;
            resp_ready_a[d] = 1'b0;
        end
        clear_models();
        reset = 1'b0;
        req_valid_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_req_ready", 32'(req_ready_a[d]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid_a[d]), 32'd0);
            check("rst_resp_rdata", resp_rdata_a[d], 32'd0);
            check("rst_resp_err", 32'(resp_err_a[d]), 32'd0);
        end
        req_valid_a[1] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("req_ready_after_rst", 32'(req_ready_a[d]), 32'd1);

        // Directed scenarios at LATENCY = 2.
        do_req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        do_req(1, 1'b1, 32'h10, 32'h0000_AB00, 4'h2, 0);
        do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        do_req(1, 1'b1, 32'h14, 32'h5555_5555, 4'h0, 0);
        do_req(1, 1'b0, 32'h13, 32'h0, 4'h0, 0);
        do_req(1, 1'b0, 32'h100, 32'h0, 4'h0, 0);
        do_req(1, 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0);
        do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        do_req(1, 1'b0, 32'h14, 32'h0, 4'h0, 0);
        check("model_partial_store", model_mem[1][4], 32'hDEAD_ABEF);

        // Reset while a store is waiting: the store is dropped and the array cleared.
        do_req(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0);
        @(negedge clk);
        req_valid_a[1] = 1'b1;
        req_we_a[1]    = 1'b1;
        req_addr_a[1]  = 32'h20;
        req_wdata_a[1] = 32'h1234_5678;
        req_wstrb_a[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready_a[1]), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid_a[1]), 32'd0);
        check("midrst_resp_rdata", resp_rdata_a[1], 32'd0);
        check("midrst_resp_err", 32'(resp_err_a[1]), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_still_idle", 32'(resp_valid_a[1]), 32'd0);
        reset = 1'b1;
        clear_models();
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        for (int i = 0; i < 40; i++) rand_req(1);

        // LATENCY = 1 and LATENCY = 15 instances.
        for (int d = 0; d < 3; d += 2) begin
            do_req(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
            do_req(d, 1'b0, 32'h10, 32'h0, 4'h0, 1);
            do_req(d, 1'b0, 32'h13, 32'h0, 4'h0, 0);
            for (int i = 0; i < ((d == 0) ? 12 : 4); i++) rand_req(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined core's data-memory port.
- Accepts one load/store request at a time through a valid/ready handshake.
- Serves it from an internal word array after a fixed, parameterised latency, then returns read data and an error flag through a valid/ready response handshake.
- Replaces the zero-latency data RAM so the core's stall logic can be exercised against a slow memory.

Parameters:
- LATENCY, 2, cycles from request acceptance to resp_valid rising; legal range 1..15.
- ADDR_W, 6, word-address width; the array holds 2^ADDR_W 32-bit words. Byte addresses 0..(4·2^ADDR_W − 1) are valid.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables for stores; bit i writes byte i (bits 8i+7:8i). Ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load data; 0 for stores and for errored requests.
- resp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; req_ready = 0 while reset is asserted.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - All array words are cleared to 0.
  - A request in flight is dropped and any pending store is discarded.
  - req_ready rises in the first cycle after reset deasserts.
- State IDLE: req_ready = 1, resp_valid = 0.
  - Handshake = req_valid & req_ready at a rising edge.
  - On handshake: latch we, addr, wdata and wstrb; load counter = LATENCY − 1; go to WAIT.
- State WAIT: req_ready = 0.
  - Counter decrements each cycle.
  - When the counter is 0 at an edge, execute the latched request and go to RESP.
  - Net effect: a request accepted at edge k gives resp_valid = 1 after edge k + LATENCY.
  - For LATENCY = 1, WAIT lasts exactly one cycle.
- Execute, done at the WAIT→RESP edge:
  - err = (addr[1:0] != 0) | (addr[31:ADDR_W+2] != 0).
  - Load, no error: resp_rdata = mem[addr[ADDR_W+1:2]].
  - Store, no error: only the enabled bytes of mem[addr[ADDR_W+1:2]] are updated; resp_rdata = 0.
  - Store with wstrb = 0: completes normally as a no-op, err = 0.
  - Any error: no array change; resp_rdata = 0; resp_err = 1.
- State RESP: resp_valid = 1; resp_rdata and resp_err stay stable until the handshake.
  - req_ready = 0.
  - On resp_valid & resp_ready: go to IDLE; resp_valid, resp_rdata and resp_err return to 0.
- Outstanding requests and throughput:
  - Only one request is outstanding at a time; req_valid is ignored outside IDLE.
  - Minimum spacing between accepts is LATENCY + 2 cycles (LATENCY in WAIT, at least one in RESP, one in IDLE).
- Ordering: a load that follows a store to the same word returns the updated data (strictly serial).
- Changes to req_* inputs after acceptance have no effect on the request being served.
- LATENCY outside 1..15 is unsupported; a simulation-time check flags it.

Test Plan:
- Reset, then store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then load addr 0x10 (LATENCY = 2) -> each resp_valid rises 2 edges after its accept; load returns 0xDEADBEEF, err = 0.
- Partial store wstrb 0x2, wdata 0x0000AB00 to the same word, then load -> returns 0xDEADABEF.
- Load from addr 0x13 and load from addr 0x100 (ADDR_W = 6) -> resp_err = 1, resp_rdata = 0; word 0x10 unchanged on a following read.
- Hold resp_ready = 0 for 5 cycles in RESP while req_valid = 1 -> resp_valid and resp_rdata stay stable; req_ready stays 0; the second request is accepted only in the cycle after the response handshake.
- Assert reset during WAIT of a store of 0x12345678 to addr 0x20 -> outputs 0 immediately; after release, a load of 0x20 returns 0x00000000.
- Repeat the first scenario with LATENCY = 1 and LATENCY = 15 -> resp_valid rises exactly 1 and 15 edges after accept.
